// File: rtl/conv_window_reader.sv
// Read-side window walker for the PE array: sweeps a KxK window over the feature map,
// drives per-tap fmap read addresses/enables and realigns returning data with a pad mask.
module conv_window_reader #(
    parameter int WIDTH    = 80,
    parameter int HEIGHT   = 8,
    parameter int WIDTH_B  = 7,
    parameter int HEIGHT_B = 3,
    parameter int K        = 3,
    parameter int DATA_W   = 8,
    parameter int MEM_LAT  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [WIDTH_B-1:0]          cols,
    input  logic [HEIGHT_B-1:0]         rows,
    input  logic                        hold,
    output logic                        busy,
    output logic                        done,
    output logic [WIDTH_B*K*K-1:0]      readi_w,
    output logic [HEIGHT_B*K*K-1:0]     readi_h,
    output logic [K*K-1:0]              en_read,
    input  logic [DATA_W*K*K-1:0]       fmaps,
    output logic [DATA_W*K*K-1:0]       fmap,
    output logic                        valid_out,
    output logic [HEIGHT_B-1:0]         out_row,
    output logic [WIDTH_B-1:0]          out_col
);

    localparam int T     = K * K;
    localparam int P     = (K - 1) / 2;
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [T-1:0]        en;
        logic                vld;
        logic [HEIGHT_B-1:0] row;
        logic [WIDTH_B-1:0]  col;
    } stage_t;

    state_t              state;
    logic [WIDTH_B-1:0]  cols_q;
    logic [WIDTH_B-1:0]  c;
    logic [HEIGHT_B-1:0] rows_q;
    logic [HEIGHT_B-1:0] r;
    logic [CNT_W-1:0]    drain_cnt;
    logic                issue;
    logic                row_end;
    logic                last_issue;
    stage_t              pipe [MEM_LAT];

    assign issue      = (state == RUN) && !hold;
    assign row_end    = (c == cols_q - 1'b1);
    assign last_issue = issue && row_end && (r == rows_q - 1'b1);

    // done and busy are registered: done is set on entry to the final DRAIN cycle,
    // which is exactly when the last window leaves the read pipeline.
    // NOTE: every state register here uses <= so all flops update from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cols_q    <= '0;
            rows_q    <= '0;
            r         <= '0;
            c         <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cols_q <= (int'(cols) > WIDTH)  ? WIDTH_B'(WIDTH)   : cols;
                        rows_q <= (int'(rows) > HEIGHT) ? HEIGHT_B'(HEIGHT) : rows;
                        r      <= '0;
                        c      <= '0;
                        busy   <= 1'b1;
                        if (cols == '0 || rows == '0) begin
                            // Empty map: one extra drain cycle stands in for the missing issue slot.
                            state     <= DRAIN;
                            drain_cnt <= CNT_W'(MEM_LAT);
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (last_issue) begin
                            state     <= DRAIN;
                            drain_cnt <= CNT_W'(MEM_LAT - 1);
                            done      <= (MEM_LAT == 1);
                        end else if (row_end) begin
                            c <= '0;
                            r <= r + 1'b1;
                        end else begin
                            c <= c + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                        done      <= (drain_cnt == CNT_W'(1));
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Tap (i, j) reads map position (r+i-P, c+j-P); out-of-map taps are disabled and addressed at 0.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin : index_gen
        int ri;
        int ci;
        int t;
        en_read = '0;
        readi_h = '0;
        readi_w = '0;
        ri      = 0;
        ci      = 0;
        t       = 0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                t  = i * K + j;
                ri = int'(r) + i - P;
                ci = int'(c) + j - P;
                if (issue && ri >= 0 && ri < int'(rows_q) && ci >= 0 && ci < int'(cols_q)) begin
                    en_read[T-1-t]                          = 1'b1;
                    readi_h[HEIGHT_B*(T-t)-1 -: HEIGHT_B]   = ri[HEIGHT_B-1:0];
                    readi_w[WIDTH_B*(T-t)-1 -: WIDTH_B]     = ci[WIDTH_B-1:0];
                end
            end
        end
    end

    // NOTE: this shift register is reset, unlike a data RAM, because it carries valid_out and
    // the pad mask; stale bits after reset would present a phantom window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < MEM_LAT; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= '{en: en_read, vld: issue, row: r, col: c};
            for (int k = 1; k < MEM_LAT; k++) pipe[k] <= pipe[k-1];
        end
    end

    assign valid_out = pipe[MEM_LAT-1].vld;
    assign out_row   = pipe[MEM_LAT-1].row;
    assign out_col   = pipe[MEM_LAT-1].col;

    always_comb begin
        fmap = '0;
        for (int t = 0; t < T; t++) begin
            if (pipe[MEM_LAT-1].en[T-1-t]) fmap[DATA_W*(T-t)-1 -: DATA_W] = fmaps[DATA_W*(T-t)-1 -: DATA_W];
        end
    end

endmodule

// File: tb/tb_conv_window_reader.sv
// Bench for conv_window_reader: a fmap memory model with MEM_LAT delay feeds the DUT and a
// scoreboard of expected windows (raster order, zero padded) is checked by a monitor.
module tb_conv_window_reader;

    localparam int WIDTH = 80, HEIGHT = 8, WB = 7, HB = 3, K = 3, DW = 8, LAT = 3;
    localparam int T = K * K, P = (K - 1) / 2;

    typedef logic [DW*T-1:0] word_t;
    typedef struct { int r; int c; word_t f; bit last; } exp_t;

    logic            clk = 1'b0;
    logic            reset, start, hold;
    logic [WB-1:0]   cols;
    logic [HB-1:0]   rows;
    logic            busy, done, valid_out;
    logic [WB*T-1:0] readi_w;
    logic [HB*T-1:0] readi_h;
    logic [T-1:0]    en_read;
    word_t           fmaps, fmap;
    logic [HB-1:0]   out_row;
    logic [WB-1:0]   out_col;

    conv_window_reader #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .WIDTH_B(WB), .HEIGHT_B(HB),
        .K(K), .DATA_W(DW), .MEM_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cols(cols), .rows(rows), .hold(hold),
        .busy(busy), .done(done), .readi_w(readi_w), .readi_h(readi_h), .en_read(en_read),
        .fmaps(fmaps), .fmap(fmap), .valid_out(valid_out), .out_row(out_row), .out_col(out_col)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    exp_t       sb[$];
    word_t      dline[$];
    logic [DW-1:0] mem [2**HB][2**WB];
    bit         tap_mode     = 1'b1;
    bit         zero_pending = 1'b0;
    bit         done_seen    = 1'b0;
    bit         prev_done    = 1'b0;
    int         valid_cnt    = 0;
    exp_t       e;
    word_t      d_mem;
    logic [HB-1:0] hi;
    logic [WB-1:0] wi;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Expected window straight from the definition: tap (i,j) shows map(r+i-P, c+j-P) or 0 off-map.
    function automatic word_t model_window(int r, int c, int nr, int nc);
        word_t w = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                int t  = i * K + j;
                int ri = r + i - P;
                int ci = c + j - P;
                if (ri >= 0 && ri < nr && ci >= 0 && ci < nc)
                    w[DW*(T-t)-1 -: DW] = tap_mode ? DW'(t) : mem[ri][ci];
            end
        end
        return w;
    endfunction

    task automatic push_sweep(int nc, int nr);
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++)
                sb.push_back('{r, c, model_window(r, c, nr, nc), (r == nr - 1 && c == nc - 1)});
    endtask

    // Monitor plus memory front end, both at the falling edge.
    initial forever begin
        @(negedge clk);
        if (valid_out === 1'b1) begin
            valid_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_valid", valid_out, 0);
            end else begin
                e = sb.pop_front();
                check("win_row", out_row, e.r);
                check("win_col", out_col, e.c);
                check("win_fmap", fmap, e.f);
                check("win_done", done, e.last);
            end
        end else if (!zero_pending) begin
            check("stray_done", done, 0);
        end
        if (prev_done) check("busy_after_done", busy, 0);
        prev_done = (done === 1'b1);
        if (done === 1'b1) done_seen = 1'b1;
        for (int t = 0; t < T; t++) begin
            hi = readi_h[HB*(T-t)-1 -: HB];
            wi = readi_w[WB*(T-t)-1 -: WB];
            if (en_read[T-1-t] === 1'b1) d_mem[DW*(T-t)-1 -: DW] = tap_mode ? DW'(t) : mem[hi][wi];
            else                         d_mem[DW*(T-t)-1 -: DW] = tap_mode ? DW'(t) : DW'($urandom);
        end
        dline.push_back(d_mem);
    end

    // Memory return path: the data read in cycle n is on fmaps during cycle n+LAT.
    initial begin
        for (int k = 0; k < LAT; k++) dline.push_back('0);
        fmaps = '0;
        forever begin
            @(posedge clk);
            #1;
            fmaps = dline.pop_front();
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic start_sweep(int nc, int nr, bit expect_windows);
        tick();
        start     = 1'b1;
        cols      = WB'(nc);
        rows      = HB'(nr);
        done_seen = 1'b0;
        valid_cnt = 0;
        if (expect_windows) push_sweep(nc, nr);
    endtask

    task automatic wait_done(int budget, string name);
        int n = 0;
        while (!done_seen && n < budget) begin
            sample();
            n++;
        end
        check(name, done_seen, 1);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, valid_out, 0);
        check({tag, "_en_read"}, en_read, 0);
        check({tag, "_readi_w"}, readi_w, 0);
        check({tag, "_readi_h"}, readi_h, 0);
        check({tag, "_out_row"}, out_row, 0);
        check({tag, "_out_col"}, out_col, 0);
        check({tag, "_fmap"}, fmap, 0);
    endtask

    initial begin
        word_t corner_exp = {8'd0, 8'd0, 8'd0, 8'd0, 8'd4, 8'd5, 8'd0, 8'd7, 8'd8};
        word_t pad_mask   = {{3*DW{1'b1}}, {3*DW{1'b0}}, {3*DW{1'b1}}};
        int nc, nr;

        for (int rr = 0; rr < 2**HB; rr++)
            for (int cc = 0; cc < 2**WB; cc++)
                mem[rr][cc] = DW'($urandom_range(1, 255));
        reset = 1'b1; start = 1'b0; hold = 1'b0; cols = '0; rows = '0;
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset");
        tick();
        reset = 1'b0;

        // Corner window, full 4x4 sweep, and a second start while busy.
        tap_mode = 1'b1;
        start_sweep(4, 4, 1'b1);
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k == 8) begin start = 1'b1; cols = 7'd2; rows = 3'd2; end
            else start = 1'b0;
            sample();
            if (k == 0) begin
                check("corner_en_read", en_read, 9'b000011011);
                check("corner_tap4_h", readi_h[HB*(T-4)-1 -: HB], 0);
                check("corner_tap4_w", readi_w[WB*(T-4)-1 -: WB], 0);
            end
            if (k == 5)       check("interior_en_read", en_read, 9'h1FF);
            if (k == 15)      check("last_en_read", en_read, 9'b110110000);
            if (k == LAT - 1) check("corner_valid_early", valid_out, 0);
            if (k == LAT) begin
                check("corner_valid", valid_out, 1);
                check("corner_row", out_row, 0);
                check("corner_col", out_col, 0);
                check("corner_fmap", fmap, corner_exp);
            end
        end
        start = 1'b0;
        wait_done(LAT + 4, "sweep_done");
        check("sweep_valid_count", valid_cnt, 16);
        check("sweep_sb_empty", sb.size(), 0);

        // Hold for three cycles at window (1,2).
        tap_mode = 1'b0;
        start_sweep(4, 4, 1'b1);
        for (int m = 0; m < 19; m++) begin
            tick();
            start = 1'b0;
            hold  = (m >= 6 && m <= 8);
            sample();
            if (m >= 6 && m <= 8)             check("hold_en_read", en_read, 0);
            if (m >= 6 + LAT && m <= 8 + LAT) check("hold_bubble", valid_out, 0);
        end
        hold = 1'b0;
        wait_done(LAT + 4, "hold_done");
        check("hold_valid_count", valid_cnt, 16);

        // Single-row map: first valid LAT+1 cycles after start, top and bottom taps padded.
        start_sweep(5, 1, 1'b1);
        for (int m = 0; m <= 4 + LAT; m++) begin
            tick();
            start = 1'b0;
            sample();
            if (m == LAT - 1) check("row_valid_early", valid_out, 0);
            if (m == LAT)     check("row_valid_first", valid_out, 1);
            if (valid_out === 1'b1) check("row_pad_mask", fmap & pad_mask, 0);
        end
        wait_done(4, "row_done");
        check("row_valid_count", valid_cnt, 5);

        // Empty maps: done only, LAT+1 cycles after start.
        for (int z = 0; z < 2; z++) begin
            zero_pending = 1'b1;
            start_sweep(z == 0 ? 0 : 3, z == 0 ? 3 : 0, 1'b0);
            for (int m = 1; m <= LAT + 1; m++) begin
                tick();
                start = 1'b0;
                sample();
                check("zero_busy", busy, 1);
                check("zero_done", done, m == LAT + 1);
                check("zero_valid", valid_out, 0);
            end
            tick();
            sample();
            check("zero_busy_fall", busy, 0);
            zero_pending = 1'b0;
        end

        // Random sweeps with random stalls and ignored restarts.
        for (int n = 0; n < 6; n++) begin
            nc = (n == 0) ? WIDTH : $urandom_range(1, WIDTH);
            nr = (n == 0) ? 7 : $urandom_range(1, 7);
            start_sweep(nc, nr, 1'b1);
            for (int b = 0; b < 2 * nc * nr + LAT + 20 && !done_seen; b++) begin
                tick();
                hold = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 15) == 0) begin
                    start = 1'b1;
                    cols  = WB'($urandom_range(0, WIDTH));
                    rows  = HB'($urandom_range(0, 7));
                end else begin
                    start = 1'b0;
                end
                sample();
            end
            start = 1'b0;
            hold  = 1'b0;
            check("rand_done", done_seen, 1);
            check("rand_valid_count", valid_cnt, nc * nr);
            check("rand_sb_empty", sb.size(), 0);
        end

        // Reset in the middle of a sweep, then a fresh sweep.
        start_sweep(4, 4, 1'b1);
        repeat (5) tick();
        start = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        sb.delete();
        tick();
        reset = 1'b0;
        repeat (LAT + 3) sample();
        check("midreset_no_done", done_seen, 0);
        start_sweep(3, 2, 1'b1);
        tick();
        start = 1'b0;
        wait_done(3 * 2 + LAT + 4, "restart_done");
        check("restart_valid_count", valid_cnt, 6);
        check("restart_sb_empty", sb.size(), 0);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
